// File: rtl/prl_rx_message_queue_if.sv
// PRL RX -> PE message bus: parsed-event push side, PE presentation side and status.
interface prl_rx_message_queue_if #(
    parameter int INFO_W = 23,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
);
    logic                       prl_rx_st_inform_pe_en;
    logic [1:0]                 prl_rx_parser_message_type;
    logic [4:0]                 prl_rx_parser_header_type;
    logic [2:0]                 prl_rx_parser_sop_type;
    logic [INFO_W-1:0]          prl_rx_parser_info;
    logic                       pe2pl_rx_ack;
    logic                       pl2pe_rx_stat_clr;
    logic                       pl2pe_rx_en;
    logic [6:0]                 pl2pe_rx_type;
    logic [2:0]                 pl2pe_rx_sop_type;
    logic [INFO_W-1:0]          pl2pe_rx_info;
    logic [$clog2(DEPTH):0]     pl2pe_rx_level;
    logic                       pl2pe_rx_ovf;
    logic [CNT_W-1:0]           pl2pe_rx_drop_cnt;

    // Handshake: pl2pe_rx_en is the valid. With ACK_MODE=1 it stays high with stable
    // data until an edge samples pe2pl_rx_ack high (one transfer per such edge); with
    // ACK_MODE=0 every en-high cycle is itself the transfer and ack is not looked at.
    modport master (
        output prl_rx_st_inform_pe_en, prl_rx_parser_message_type, prl_rx_parser_header_type,
        output prl_rx_parser_sop_type, prl_rx_parser_info, pe2pl_rx_ack, pl2pe_rx_stat_clr,
        input  pl2pe_rx_en, pl2pe_rx_type, pl2pe_rx_sop_type, pl2pe_rx_info,
        input  pl2pe_rx_level, pl2pe_rx_ovf, pl2pe_rx_drop_cnt
    );

    modport slave (
        input  prl_rx_st_inform_pe_en, prl_rx_parser_message_type, prl_rx_parser_header_type,
        input  prl_rx_parser_sop_type, prl_rx_parser_info, pe2pl_rx_ack, pl2pe_rx_stat_clr,
        output pl2pe_rx_en, pl2pe_rx_type, pl2pe_rx_sop_type, pl2pe_rx_info,
        output pl2pe_rx_level, pl2pe_rx_ovf, pl2pe_rx_drop_cnt
    );
endinterface

// File: rtl/prl_rx_message_queue.sv
// FIFO of parsed PRL RX message events presented to the policy engine, with
// held valid/ack or single-pulse presentation and sticky overflow accounting.
module prl_rx_message_queue #(
    parameter int INFO_W   = 23,
    parameter int DEPTH    = 4,
    parameter bit ACK_MODE = 1'b1,
    parameter int CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    prl_rx_message_queue_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = 7 + 3 + INFO_W;
    localparam logic [LVL_W-1:0] FULL    = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [ENT_W-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LVL_W-1:0]  level;
    logic              en_q;
    logic [6:0]        type_q;
    logic [2:0]        sop_q;
    logic [INFO_W-1:0] info_q;
    logic              ovf_q;
    logic [CNT_W-1:0]  drop_q;

    logic              pop;
    logic              push_ok;
    logic              drop;
    logic [LVL_W-1:0]  level_after_pop;
    logic [AW-1:0]     rd_ptr_next;
    logic [ENT_W-1:0]  wr_entry;
    logic [ENT_W-1:0]  head_next;

    assign pop             = en_q & (ACK_MODE ? bus.pe2pl_rx_ack : 1'b1);
    // A pop frees a slot in the same cycle, so a full queue still accepts the push.
    assign push_ok         = bus.prl_rx_st_inform_pe_en & ((level != FULL) | pop);
    assign drop            = bus.prl_rx_st_inform_pe_en & (level == FULL) & ~pop;
    assign level_after_pop = level - LVL_W'(pop);
    assign rd_ptr_next     = rd_ptr + AW'(pop);
    assign wr_entry        = {bus.prl_rx_parser_message_type, bus.prl_rx_parser_header_type,
                              bus.prl_rx_parser_sop_type, bus.prl_rx_parser_info};
    assign head_next       = mem[rd_ptr_next];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // The presented entry is reloaded from entries already held before this edge,
    // which gives the push-to-valid latency of two edges and no input-to-output path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            en_q   <= 1'b0;
            type_q <= '0;
            sop_q  <= '0;
            info_q <= '0;
        end else begin
            rd_ptr <= rd_ptr_next;
            level  <= level_after_pop + LVL_W'(push_ok);
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (level_after_pop != '0) begin
                en_q                     <= 1'b1;
                {type_q, sop_q, info_q}  <= head_next;
            end else begin
                en_q <= 1'b0;
            end
        end
    end

    // Clear wins over the old value but not over a drop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else if (bus.pl2pe_rx_stat_clr) begin
            ovf_q  <= drop;
            drop_q <= CNT_W'(drop);
        end else if (drop) begin
            ovf_q <= 1'b1;
            if (drop_q != CNT_MAX) begin
                drop_q <= drop_q + CNT_W'(1);
            end
        end
    end

    assign bus.pl2pe_rx_en       = en_q;
    assign bus.pl2pe_rx_type     = type_q;
    assign bus.pl2pe_rx_sop_type = sop_q;
    assign bus.pl2pe_rx_info     = info_q;
    assign bus.pl2pe_rx_level    = level;
    assign bus.pl2pe_rx_ovf      = ovf_q;
    assign bus.pl2pe_rx_drop_cnt = drop_q;
endmodule
